// File: rtl/sweep_instr_packer_if.sv
// Byte-stream and instruction-FIFO write bus of the sweep/PLL instruction packer.
//   in_data/in_valid/in_ready : byte handshake from the host bridge
//   fifo_full                 : instruction FIFO back-pressure
//   fifo_wr_en/fifo_wr_data   : registered write strobe and 88-bit word
// master = host/FIFO side, slave = packer side.
interface sweep_instr_packer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [87:0] fifo_wr_data;

    modport master (
        output in_data, in_valid, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  in_data, in_valid, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/sweep_instr_packer.sv
// Write side of the 88-bit sweeper/PLL instruction FIFO.
// Frames a host byte stream (SYNC, 11 payload bytes MSB first, XOR check byte),
// validates it and pushes the assembled word into the instruction FIFO.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   bus         : byte handshake and FIFO write bus (slave modport)
//   frame_ok    : one-cycle pulse, word written
//   frame_err   : one-cycle pulse, frame dropped
//   err_code    : 01 checksum, 10 reserved bits, 11 timeout; held until next error
//   ok_count    : saturating count of written words
//   err_count   : saturating count of dropped frames
//   busy        : high whenever a frame is in progress
module sweep_instr_packer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sweep_instr_packer_if.slave  bus,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [CNT_W-1:0]     ok_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 busy
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, PUSH} state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         xor_q, xor_d;
    logic [87:0]        word_q, word_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               wr_en_q, wr_en_d;
    logic [87:0]        wr_data_q, wr_data_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic [CNT_W-1:0]   okc_q, okc_d;
    logic [CNT_W-1:0]   errc_q, errc_d;

    logic               accept;
    logic               fail;
    logic [1:0]         fail_code;

    assign accept = bus.in_valid && (state_q != PUSH);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        word_d    = word_q;
        gap_d     = '0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        okc_d     = okc_q;
        errc_d    = errc_q;
        fail      = 1'b0;
        fail_code = 2'b00;

        case (state_q)
            HUNT: begin
                if (accept && bus.in_data == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    word_d = {word_q[79:0], bus.in_data};
                    xor_d  = xor_q ^ bus.in_data;
                    if (idx_q == 4'd10) state_d = CHECK;
                    else                idx_d   = idx_q + 4'd1;
                end else if (gap_q == GAP_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            CHECK: begin
                if (accept) begin
                    if (bus.in_data != xor_q) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end else if (word_q[86:80] != 7'd0) begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end else begin
                        state_d = PUSH;
                    end
                end else if (gap_q == GAP_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            PUSH: begin
                if (!bus.fifo_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = word_q;
                    ok_d      = 1'b1;
                    if (okc_q != '1) okc_d = okc_q + 1'b1;
                    state_d   = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        if (fail) begin
            err_d   = 1'b1;
            code_d  = fail_code;
            if (errc_q != '1) errc_d = errc_q + 1'b1;
            state_d = HUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            xor_q     <= '0;
            word_q    <= '0;
            gap_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            okc_q     <= '0;
            errc_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            word_q    <= word_d;
            gap_q     <= gap_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            code_q    <= code_d;
            okc_q     <= okc_d;
            errc_q    <= errc_d;
        end
    end

    assign bus.in_ready     = (state_q != PUSH);
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign frame_ok         = ok_q;
    assign frame_err        = err_q;
    assign err_code         = code_q;
    assign ok_count         = okc_q;
    assign err_count        = errc_q;
    assign busy             = (state_q != HUNT);

endmodule
